// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map and bit positions shared by the UART RX controller
package uart_pkg;

   typedef enum logic [1:0] {
      eUartReg_Data   = 2'd0,
      eUartReg_Status = 2'd1,
      eUartReg_Ctrl   = 2'd2,
      eUartReg_Level  = 2'd3
   } uart_reg_e;

   localparam int STAT_OVR_BIT     = 7;
   localparam int STAT_FULL_BIT    = 6;
   localparam int STAT_EMPTY_BIT   = 5;
   localparam int STAT_COUNT_W     = 5;

   localparam int CTRL_RX_IEN_BIT  = 0;
   localparam int CTRL_OVR_IEN_BIT = 1;
   localparam int CTRL_FLUSH_BIT   = 2;

   localparam int LEVEL_W          = 5;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with flush and look-ahead count
module sync_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_head,
   output logic [CW-1:0]    o_count,
   output logic [CW-1:0]    o_count_next,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_push_ok
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_pop_ok;
   logic             w_push_ok;
   logic [CW-1:0]    w_count_next;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop_ok  = i_pop && !w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok = i_push && !i_flush && (!w_full || w_pop_ok);

   always_comb begin
      w_count_next = r_count;
      if (i_flush)
         w_count_next = '0;
      else if (w_push_ok && !w_pop_ok)
         w_count_next = r_count + CW'(1);
      else if (!w_push_ok && w_pop_ok)
         w_count_next = r_count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_next;
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_head       = r_mem[r_rd_ptr];
   assign o_count      = r_count;
   assign o_count_next = w_count_next;
   assign o_full       = w_full;
   assign o_empty      = w_empty;
   assign o_push_ok    = w_push_ok;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - Wishbone register front end, RX FIFO, overrun policy and irq
// Overrun flag, STATUS bit7 and ovr_ien exist only with UART_RX_CTRL_OVERRUN_EN defined.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       wb_stb,
   input  logic       wb_we,
   input  logic [1:0] wb_adr,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack,
   output logic       irq
);

   localparam int           CW      = $clog2(DEPTH) + 1;
   localparam logic [4:0]   DEPTH_L = 5'(DEPTH);

   logic [7:0]         w_head;
   logic [CW-1:0]      w_count;
   logic [CW-1:0]      w_count_next;
   logic               w_full;
   logic               w_empty;
   logic               w_push_ok;

   logic               r_ack;
   logic [7:0]         r_dat_o;
   logic               r_irq;
   logic               r_rx_ien;
   logic [LEVEL_W-1:0] r_level;

   logic               w_accept;
   uart_reg_e          w_adr;
   logic               w_pop;
   logic               w_flush;
   logic [LEVEL_W-1:0] w_level_wr;
   logic [7:0]         w_status;
   logic               w_overrun;
   logic               w_ovr_ien;
   logic               w_irq_ovr;
   logic               w_unused;

   assign w_accept = wb_stb && !r_ack;
   assign w_adr    = uart_reg_e'(wb_adr);
   assign w_pop    = w_accept && !wb_we && (w_adr == eUartReg_Data);
   assign w_flush  = w_accept && wb_we && (w_adr == eUartReg_Ctrl) && wb_dat_i[CTRL_FLUSH_BIT];

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (rx_valid),
      .i_push_data  (rx_data),
      .i_pop        (w_pop),
      .i_flush      (w_flush),
      .o_head       (w_head),
      .o_count      (w_count),
      .o_count_next (w_count_next),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_push_ok    (w_push_ok)
   );

`ifdef UART_RX_CTRL_OVERRUN_EN
   logic r_overrun;
   logic r_ovr_ien;
   logic w_ovr_set;
   logic w_ovr_clr;
   logic w_overrun_next;

   // A flush discards the coincident push without counting it as an overrun.
   assign w_ovr_set      = rx_valid && !w_push_ok && !w_flush;
   assign w_ovr_clr      = w_accept && wb_we && (w_adr == eUartReg_Status) && wb_dat_i[STAT_OVR_BIT];
   assign w_overrun_next = w_ovr_set || (r_overrun && !w_ovr_clr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
         r_ovr_ien <= 1'b0;
      end else begin
         r_overrun <= w_overrun_next;
         if (w_accept && wb_we && (w_adr == eUartReg_Ctrl))
            r_ovr_ien <= wb_dat_i[CTRL_OVR_IEN_BIT];
      end
   end

   assign w_overrun = r_overrun;
   assign w_ovr_ien = r_ovr_ien;
   assign w_irq_ovr = r_ovr_ien && w_overrun_next;
`else
   assign w_overrun = 1'b0;
   assign w_ovr_ien = 1'b0;
   assign w_irq_ovr = 1'b0;
`endif

   assign w_status = {w_overrun, w_full, w_empty, STAT_COUNT_W'(w_count)};

   always_comb begin
      w_level_wr = wb_dat_i[LEVEL_W-1:0];
      if (w_level_wr == '0)
         w_level_wr = 5'd1;
      else if (w_level_wr > DEPTH_L)
         w_level_wr = DEPTH_L;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack    <= 1'b0;
         r_dat_o  <= 8'h00;
         r_irq    <= 1'b0;
         r_rx_ien <= 1'b0;
         r_level  <= 5'd1;
      end else begin
         r_ack <= w_accept;
         r_irq <= (r_rx_ien && (5'(w_count_next) >= r_level)) || w_irq_ovr;
         if (w_accept) begin
            if (wb_we) begin
               case (w_adr)
                  eUartReg_Ctrl:  r_rx_ien <= wb_dat_i[CTRL_RX_IEN_BIT];
                  eUartReg_Level: r_level  <= w_level_wr;
                  default: ;
               endcase
            end else begin
               case (w_adr)
                  eUartReg_Data:   r_dat_o <= w_empty ? 8'h00 : w_head;
                  eUartReg_Status: r_dat_o <= w_status;
                  eUartReg_Ctrl:   r_dat_o <= {6'b0, w_ovr_ien, r_rx_ien};
                  eUartReg_Level:  r_dat_o <= {3'b0, r_level};
               endcase
            end
         end
      end
   end

   assign w_unused = ^{wb_dat_i[7:5], w_push_ok};

   assign wb_ack   = r_ack;
   assign wb_dat_o = r_dat_o;
   assign irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed table-driven bench for uart_rx_ctrl (DEPTH=8)
module tb_uart_rx_ctrl;

`ifdef UART_RX_CTRL_OVERRUN_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_LEVL = 2'd3;
   localparam int OP_PUSH = 0, OP_READ = 1, OP_WRITE = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       wb_stb;
   logic       wb_we;
   logic [1:0] wb_adr;
   logic [7:0] wb_dat_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack;
   logic       irq;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int         op;
      logic [1:0] adr;
      logic [7:0] dat;
      logic [7:0] exp;
   } vec_t;

   vec_t vq[$];

   uart_rx_ctrl #(.DEPTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .wb_stb   (wb_stb),
      .wb_we    (wb_we),
      .wb_adr   (wb_adr),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack   (wb_ack),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input int op, input logic [1:0] adr, input logic [7:0] dat, input logic [7:0] exp);
      vec_t v;
      v.op = op; v.adr = adr; v.dat = dat; v.exp = exp;
      vq.push_back(v);
   endtask

   task automatic push(input logic [7:0] d);
      rx_valid = 1'b1;
      rx_data  = d;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   // Called 1 ns after a rising edge; returns 1 ns after the edge where ack has dropped.
   task automatic bus(input bit we, input logic [1:0] adr, input logic [7:0] din,
                      input bit with_push, input logic [7:0] pdata, output logic [7:0] dout);
      int cyc;
      wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = din;
      if (with_push) begin
         rx_valid = 1'b1;
         rx_data  = pdata;
      end
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         rx_valid = 1'b0;
         cyc++;
         if (wb_ack) break;
      end
      check("ack_latency", cyc, 1);
      dout   = wb_dat_o;
      wb_stb = 1'b0;
      @(posedge clk); #1;
      check("ack_drop", {31'b0, wb_ack}, 0);
   endtask

   task automatic rd(input logic [1:0] adr, output logic [7:0] dout);
      bus(1'b0, adr, 8'h00, 1'b0, 8'h00, dout);
   endtask

   task automatic wr(input logic [1:0] adr, input logic [7:0] din);
      logic [7:0] dummy;
      bus(1'b1, adr, din, 1'b0, 8'h00, dummy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      int acks;

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 2'd0; wb_dat_i = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ack", {31'b0, wb_ack}, 0);
      check("rst_dat", {24'b0, wb_dat_o}, 0);
      check("rst_irq", {31'b0, irq}, 0);

      add(OP_READ, A_STAT, 0, 8'h20);
      add(OP_READ, A_CTRL, 0, 8'h00);
      add(OP_READ, A_LEVL, 0, 8'h01);
      add(OP_PUSH, 0, 8'h41, 0);
      add(OP_PUSH, 0, 8'h42, 0);
      add(OP_PUSH, 0, 8'h43, 0);
      add(OP_READ, A_STAT, 0, 8'h03);
      add(OP_READ, A_DATA, 0, 8'h41);
      add(OP_READ, A_DATA, 0, 8'h42);
      add(OP_READ, A_DATA, 0, 8'h43);
      add(OP_READ, A_DATA, 0, 8'h00);
      add(OP_READ, A_STAT, 0, 8'h20);
      for (int i = 0; i < 9; i++) add(OP_PUSH, 0, 8'(i), 0);
      add(OP_READ, A_STAT, 0, OVR ? 8'hC8 : 8'h48);
      add(OP_WRITE, A_STAT, 8'h80, 0);
      add(OP_READ, A_STAT, 0, 8'h48);
      for (int i = 0; i < 8; i++) add(OP_READ, A_DATA, 0, 8'(i));
      add(OP_READ, A_DATA, 0, 8'h00);
      add(OP_READ, A_STAT, 0, 8'h20);
      add(OP_WRITE, A_LEVL, 8'h00, 0);
      add(OP_READ, A_LEVL, 0, 8'h01);
      add(OP_WRITE, A_LEVL, 8'h1F, 0);
      add(OP_READ, A_LEVL, 0, 8'h08);
      add(OP_WRITE, A_LEVL, 8'h05, 0);
      add(OP_READ, A_LEVL, 0, 8'h05);
      add(OP_WRITE, A_LEVL, 8'h01, 0);
      add(OP_WRITE, A_CTRL, 8'hFF, 0);
      add(OP_READ, A_CTRL, 0, OVR ? 8'h03 : 8'h01);
      add(OP_WRITE, A_CTRL, 8'h00, 0);
      add(OP_READ, A_CTRL, 0, 8'h00);
      add(OP_PUSH, 0, 8'h55, 0);
      add(OP_WRITE, A_DATA, 8'hAA, 0);
      add(OP_READ, A_DATA, 0, 8'h55);
      add(OP_READ, A_STAT, 0, 8'h20);

      foreach (vq[i]) begin
         case (vq[i].op)
            OP_PUSH:  push(vq[i].dat);
            OP_WRITE: wr(vq[i].adr, vq[i].dat);
            default: begin
               rd(vq[i].adr, d);
               check($sformatf("vec%0d_adr%0d", i, vq[i].adr), {24'b0, d}, {24'b0, vq[i].exp});
            end
         endcase
      end

      // irq threshold: asserts the cycle after the third push, drops after one pop
      wr(A_LEVL, 8'h03);
      wr(A_CTRL, 8'h01);
      push(8'hA1);
      push(8'hA2);
      check("irq_below_level", {31'b0, irq}, 0);
      push(8'hA3);
      check("irq_at_level", {31'b0, irq}, 1);
      rd(A_DATA, d);
      check("irq_pop_data", {24'b0, d}, 8'hA1);
      check("irq_after_pop", {31'b0, irq}, 0);
      wr(A_CTRL, 8'h04);
      wr(A_LEVL, 8'h01);
      rd(A_STAT, d);
      check("irq_flush_status", {24'b0, d}, 8'h20);

      // push coincident with a DATA read while full
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      bus(1'b0, A_DATA, 8'h00, 1'b1, 8'h18, d);
      check("full_pop_head", {24'b0, d}, 8'h10);
      rd(A_STAT, d);
      check("full_pop_status", {24'b0, d}, 8'h48);
      for (int i = 1; i <= 8; i++) begin
         rd(A_DATA, d);
         check($sformatf("full_pop_data%0d", i), {24'b0, d}, {24'b0, 8'h10 + 8'(i)});
      end
      rd(A_STAT, d);
      check("full_pop_drained", {24'b0, d}, 8'h20);

      // flush coincident with a push
      for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
      bus(1'b1, A_CTRL, 8'h04, 1'b1, 8'h99, d);
      rd(A_STAT, d);
      check("flush_status", {24'b0, d}, 8'h20);
      rd(A_CTRL, d);
      check("flush_ctrl", {24'b0, d}, 8'h00);
      rd(A_DATA, d);
      check("flush_data", {24'b0, d}, 8'h00);

      // stb held high: one access per two cycles
      wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_STAT;
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         acks += int'(wb_ack);
      end
      wb_stb = 1'b0;
      check("b2b_acks", acks, 2);
      @(posedge clk); #1;

      // reset while an ack is pending
      push(8'h71);
      push(8'h72);
      wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_DATA;
      @(posedge clk); #1;
      rst = 1'b1; wb_stb = 1'b0;
      @(posedge clk); #1;
      check("midrst_ack", {31'b0, wb_ack}, 0);
      check("midrst_dat", {24'b0, wb_dat_o}, 0);
      rst = 1'b0;
      rd(A_STAT, d);
      check("midrst_status", {24'b0, d}, 8'h20);
      rd(A_LEVL, d);
      check("midrst_level", {24'b0, d}, 8'h01);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
